spi_baud_generator: RTL and testbench

- Downstream of spi_apb_slave. Consumes its configuration outputs (sppr, spr, cpol, cpha, spiswai, spi_mode) plus the slave-select line.
- Generates the SPI serial clock (sclk) and single-pclk sample/shift strobes for the shift-register stage.
- Exports the active baud-rate divisor for status and debug.
- Sole source of SCK timing in the SPI master path.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_baud_generator.sv | 96 +++++++++
 tb/tb_spi_baud_generator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: operating modes, widths,
// APB register map and baud-generator state encoding.
package spi_pkg;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  localparam int DIV_W = 12;
  localparam int CNT_W = 11;

  localparam logic [2:0] SPI_CR1_ADDR = 3'h0;
  localparam logic [2:0] SPI_CR2_ADDR = 3'h1;
  localparam logic [2:0] SPI_BR_ADDR  = 3'h2;
  localparam logic [2:0] SPI_SR_ADDR  = 3'h3;
  localparam logic [2:0] SPI_DR_ADDR  = 3'h5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bg_state_e;

endpackage

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: divides pclk by the programmed
// baud divisor and emits one-pclk sample/shift strobes.
module spi_baud_generator #(
  parameter int DIV_W = spi_pkg::DIV_W,
  parameter int CNT_W = spi_pkg::CNT_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [1:0]       spi_mode_i,
  input  logic             spiswai_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  input  logic             ss_i,
  output logic             sclk_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic [DIV_W-1:0] baud_div_o
);

  import spi_pkg::*;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] pre;
  logic [CNT_W-1:0] half;
  logic             sclk_q;
  logic             sclk_d;
  logic             smp_q;
  logic             smp_d;
  logic             sft_q;
  logic             sft_d;
  logic             en;
  logic             wrap;
  logic             lead;
  bg_state_e        state;

  always_comb begin
    pre  = CNT_W'(sppr_i) + CNT_W'(1);
    half = pre << spr_i;
  end

  assign baud_div_o = DIV_W'(half) << 1;

  assign en = ~ss_i
            & ((spi_mode_i == SPI_RUN)
            |  ((spi_mode_i == SPI_WAIT) & ~spiswai_i));

  assign state = en ? ST_RUN : ST_IDLE;

  // >= so a shrinking divisor wraps at once
  assign wrap = cnt_q >= (half - CNT_W'(1));
  assign lead = sclk_q == cpol_i;

  always_comb begin
    cnt_d  = '0;
    sclk_d = sclk_q;
    smp_d  = 1'b0;
    sft_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        sclk_d = cpol_i;
      end
      ST_RUN: begin
        if (wrap) begin
          sclk_d = ~sclk_q;
          smp_d  = lead ^ cpha_i;
          sft_d  = ~(lead ^ cpha_i);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      smp_q  <= 1'b0;
      sft_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      smp_q  <= smp_d;
      sft_q  <= sft_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign sample_o = smp_q;
  assign shift_o  = sft_q;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Bench for spi_baud_generator: expected strobe events are
// queued by the stimulus and matched by a strobe monitor.
module tb_spi_baud_generator;

  logic        pclk;
  logic        preset_n;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        ss_i;
  logic        sclk_o;
  logic        sample_o;
  logic        shift_o;
  logic [11:0] baud_div_o;

  typedef struct {
    int cyc;
    bit smp;
    bit sclk;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  spi_baud_generator dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .spi_mode_i (spi_mode_i),
    .spiswai_i  (spiswai_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .sppr_i     (sppr_i),
    .spr_i      (spr_i),
    .ss_i       (ss_i),
    .sclk_o     (sclk_o),
    .sample_o   (sample_o),
    .shift_o    (shift_o),
    .baud_div_o (baud_div_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // k-th toggle lands at base+k*half; odd k is a leading edge
  task automatic push_edges(input int base, input int half,
                            input int n, input bit cpol,
                            input bit cpha);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.cyc  = base + k * half;
      e.smp  = (k % 2 == 1) ? !cpha : cpha;
      e.sclk = (k % 2 == 1) ? !cpol : cpol;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge pclk) begin
    if (sample_o || shift_o) begin
      if (sample_o && shift_o) chk("both_strobes", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_cyc", cyc, -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_cyc", cyc, e.cyc);
        chk("strobe_kind_sample", int'(sample_o), int'(e.smp));
        chk("strobe_sclk", int'(sclk_o), int'(e.sclk));
      end
    end
  end

  // Run n edges at a given rate, then drop ss p cycles later
  task automatic seg(input bit [2:0] sppr, input bit [2:0] spr,
                     input bit cpol, input bit cpha,
                     input bit [1:0] mode, input bit swai,
                     input int half, input int div,
                     input int n, input int p);
    int base;
    sppr_i = sppr; spr_i = spr; cpol_i = cpol; cpha_i = cpha;
    spi_mode_i = mode; spiswai_i = swai; ss_i = 1'b1;
    @(negedge pclk);
    chk("baud_div", int'(baud_div_o), div);
    chk("idle_sclk", int'(sclk_o), int'(cpol));
    base = cyc;
    ss_i = 1'b0;
    push_edges(base, half, n, cpol, cpha);
    repeat (n * half + p) @(negedge pclk);
    ss_i = 1'b1;
    @(negedge pclk);
    chk("ss_stop_sclk", int'(sclk_o), int'(cpol));
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    int base;
    n_tests = 0;
    n_fail  = 0;
    preset_n = 1'b0;
    spi_mode_i = 2'b00; spiswai_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0;
    sppr_i = 3'd0; spr_i = 3'd0; ss_i = 1'b1;
    #3;
    chk("rst_sclk", int'(sclk_o), 0);
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_shift", int'(shift_o), 0);
    chk("rst_baud_div", int'(baud_div_o), 2);
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);

    // fastest rate, mode 0
    seg(3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 2, 6, 0);
    // half = 4, cpha = 1
    seg(3'd1, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 4, 8, 4, 2);
    // idle high, stop mid-period
    seg(3'd0, 3'd1, 1'b1, 1'b0, 2'b00, 1'b0, 2, 4, 3, 1);

    // wait mode with spiswai set: halted
    spi_mode_i = 2'b01; spiswai_i = 1'b1; ss_i = 1'b0;
    repeat (10) @(negedge pclk);
    chk("wait_halt_sclk", int'(sclk_o), 1);
    ss_i = 1'b1;
    @(negedge pclk);
    // wait mode, spiswai clear: half = 3
    seg(3'd2, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0, 3, 6, 4, 1);
    // stop mode: halted
    spi_mode_i = 2'b10; spiswai_i = 1'b0; ss_i = 1'b0;
    repeat (10) @(negedge pclk);
    chk("stop_halt_sclk", int'(sclk_o), 1);
    ss_i = 1'b1;

    // divisor shrink mid-count
    cpol_i = 1'b0; cpha_i = 1'b0; spi_mode_i = 2'b00;
    sppr_i = 3'd7; spr_i = 3'd7;
    @(negedge pclk);
    @(negedge pclk);
    chk("baud_div_max", int'(baud_div_o), 2048);
    ss_i = 1'b0;
    repeat (500) @(negedge pclk);
    chk("no_early_edge_sclk", int'(sclk_o), 0);
    sppr_i = 3'd0; spr_i = 3'd0;
    push_edges(cyc, 1, 5, 1'b0, 1'b0);
    repeat (5) @(negedge pclk);
    ss_i = 1'b1;
    @(negedge pclk);
    chk("shrink_stop_sclk", int'(sclk_o), 0);

    // async reset mid-run
    @(negedge pclk);
    base = cyc;
    ss_i = 1'b0;
    push_edges(base, 1, 3, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    #1 preset_n = 1'b0;
    #1;
    chk("arst_sclk", int'(sclk_o), 0);
    chk("arst_sample", int'(sample_o), 0);
    chk("arst_shift", int'(shift_o), 0);
    repeat (2) @(negedge pclk);
    push_edges(cyc, 1, 4, 1'b0, 1'b0);
    preset_n = 1'b1;
    repeat (4) @(negedge pclk);
    ss_i = 1'b1;
    @(negedge pclk);
    chk("post_rst_stop_sclk", int'(sclk_o), 0);
    repeat (3) @(negedge pclk);

    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
